uart_rx_param: RTL
==================

# uart_rx_param

Parametrised asynchronous serial receiver that oversamples `serial_in`, validates the start bit, and samples data, optional parity, and stop at bit centre. It delivers each word LSB-first-assembled through a valid/ready holding register with framing, parity and overrun flags. It sits between the board-level serial pin and the design's byte-stream consumers. It supersedes the fixed 8-bit, clock-per-bit receiver.

## Interface
- `DATA_BITS`, 8, word length, legal 5..9.
- `CLKS_PER_BIT`, 16, clock cycles per serial bit, even, legal 4..1024; `HALF = CLKS_PER_BIT/2`.
- `PARITY_ODD`, 0, parity sense when parity is compiled in: 0 = even, 1 = odd.
- `clock`  in  1  single system clock; all flops rise-edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `serial_in`  in  1  asynchronous serial line, idle high.
- `data`  out  DATA_BITS  received word; stable while `data_valid`=1.
- `data_valid`  out  1  holding register full.
- `data_ready`  in  1  consumer accepts the word when `data_valid`=1 and `data_ready`=1 at a clock edge.
- `framing_err`  out  1  the held word had stop bit sampled 0.
- `parity_err`  out  1  the held word failed the parity check; constant 0 when parity is compiled out.
- `overrun`  out  1  the held word overwrote an unaccepted word.
- `busy`  out  1  FSM not in IDLE.

## Operation
- Two-flop synchronizer on `serial_in` produces `rx_s`; both flops and edge flop `rx_prev` reset to 1.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP. Bit counter `cnt`, width clog2(CLKS_PER_BIT); index `bit_idx`.
- IDLE: `rx_s`=0 and `rx_prev`=1 (falling edge) -> START, `cnt`=0. A line held low never retriggers; a new falling edge is required.
- START: `cnt` increments; at `cnt`=HALF-1, `rx_s`=0 -> DATA with `cnt`=0 and `bit_idx`=0; `rx_s`=1 -> IDLE (glitch rejected, nothing delivered).
- DATA, PARITY, and STOP each wait until `cnt`=CLKS_PER_BIT-1, sample `rx_s` on that edge, and clear `cnt`.
- DATA: the sample shifts into the MSB of the DATA_BITS shift register, shifting right, so the first bit ends in `data[0]`. After `bit_idx`=DATA_BITS-1 the FSM goes to PARITY, or to STOP if parity is compiled out.
- PARITY: stores the sampled bit. Mismatch means (XOR of data bits) XOR (parity bit) is not equal to `PARITY_ODD`.
- STOP sample edge, called the completion edge:
  - Load `data`, set `data_valid`=1.
  - `framing_err`=~`rx_s`; `parity_err`=mismatch.
  - `overrun`=1 if `data_valid` was 1 and not accepted on this edge, else 0.
  - FSM goes to IDLE, so a start edge in the second half of the stop bit is caught.
- Accept edge without completion: `data_valid`, `framing_err`, `parity_err`, and `overrun` clear to 0; `data` holds its value.
- Completion and accept on the same edge: the old word is consumed, the new word is loaded, `data_valid` stays 1, and `overrun`=0.
- Errored frames are still delivered, with their flags set.

## Timing
- Reset values: `data`=0, `data_valid`=0, `framing_err`=0, `parity_err`=0, `overrun`=0, `busy`=0, FSM=IDLE. Reset asserted mid-frame discards the partial word and any held word.
- Let E be the first edge at which synchronizer flop 1 captures `serial_in`=0:
  - IDLE->START occurs at edge E+2, so `busy` rises after E+2.
  - The start check occurs at edge E+2+HALF.
  - The completion edge is E+2+HALF+(DATA_BITS+P+1)*CLKS_PER_BIT, with P=1 when parity is compiled in, else 0.
  - Default 8N1 at 16 clocks/bit: completion at E+154.
- `data_valid` and flags change only on completion or accept edges; there is no combinational path from `data_ready` to any output.
- Back-to-back frames are sustained with zero idle bits between stop and the next start.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The PARITY state is compiled in, and one parity bit is expected after the data bits.
  - `parity_err` is driven, with its sense set by `PARITY_ODD`.
- Not defined:
  - No parity bit is expected; frame is start + DATA_BITS + stop.
  - `parity_err` is tied 0, and `PARITY_ODD` is ignored.

## Test plan
- Default params, no macro, send 0xA5 8N1, `data_ready`=1 -> `data`=0xA5, `data_valid` pulses 1 cycle after edge E+154, all flags 0.
- Low pulse of 6 clocks on idle line -> START rejects at E+10, `busy` returns 0, no `data_valid`.
- Send 0x3C then 0x81 back-to-back with `data_ready`=0 -> after second completion `data`=0x81, `data_valid`=1, `overrun`=1; one accept clears all flags.
- Send 0x55 with stop bit forced 0, line then held low 40 bits -> `framing_err`=1 with `data`=0x55; no further frame until the line goes high then low.
- Macro defined, `PARITY_ODD`=0, send 0x07 with parity bit 0 -> `parity_err`=1; with parity bit 1 -> `parity_err`=0.
- `DATA_BITS`=5, `CLKS_PER_BIT`=4: assert `reset` low mid-data of a frame, release, then send 0x13 -> outputs 0 during reset, then `data`=0x13 clean.

Source files
------------

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with valid/ready holding register and error flags.
// Define UART_RX_PARITY_EN to expect one parity bit after the data bits.
module uart_rx_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 framing_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int IW   = $clog2(DATA_BITS);

  localparam logic [CW-1:0] C_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state;
  logic                 sync1;
  logic                 rx_s;
  logic                 rx_prev;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 accept;
  logic                 mismatch;

  assign accept = data_valid && data_ready;
  assign busy   = (state != IDLE);

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  assign mismatch = (((^shreg) ^ par_bit) != PARITY_ODD);
`else
  assign mismatch = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1       <= 1'b1;
      rx_s        <= 1'b1;
      rx_prev     <= 1'b1;
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      data        <= '0;
      data_valid  <= 1'b0;
      framing_err <= 1'b0;
      parity_err  <= 1'b0;
      overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit     <= 1'b0;
`endif
    end else begin
      sync1   <= serial_in;
      rx_s    <= sync1;
      rx_prev <= rx_s;

      // A completion later in this block overrides the accept clear.
      if (accept) begin
        data_valid  <= 1'b0;
        framing_err <= 1'b0;
        parity_err  <= 1'b0;
        overrun     <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (!rx_s && rx_prev) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == C_HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == C_LAST) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == I_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == C_LAST) begin
            cnt     <= '0;
            par_bit <= rx_s;
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt == C_LAST) begin
            cnt         <= '0;
            data        <= shreg;
            data_valid  <= 1'b1;
            framing_err <= ~rx_s;
            parity_err  <= mismatch;
            overrun     <= data_valid && !data_ready;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
